imem_loader: RTL

- Boot-time program loader directly upstream of the processor's instruction memory.
- Receives a byte stream over a valid/ready handshake and assembles it into big-endian 32-bit words.
- Writes each word into the instruction memory write port and validates the stream with an XOR checksum.
- Holds the processor in reset (cpu_rst) until a load completes successfully; the processor top ORs cpu_rst into its own rst.

---
 rtl/imem_loader_pkg.sv | 21 ++
 rtl/imem_loader_byte_packer.sv | 47 ++++
 rtl/imem_loader.sv | 121 ++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_LEN_HI = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_DATA   = 3'd2,
    ST_CSUM   = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
  } state_e;

  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

  // One step of the stream checksum: an 8-bit XOR fold.
  function automatic logic [7:0] csum_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs bytes big-endian into a 32-bit word; pulses o_word_valid the cycle
// after the fourth byte of a word is accepted.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        i_clear,
  input  logic        i_byte_en,
  input  logic [7:0]  i_byte,
  output logic        o_last_byte,
  output logic        o_word_valid,
  output logic [31:0] o_word
);

  localparam int LANE_W = $clog2(BYTES_PER_WORD);

  logic [LANE_W-1:0] r_lane;
  logic [23:0]       r_shift;
  logic [31:0]       r_word;
  logic              r_word_valid;

  assign o_last_byte  = (r_lane == LANE_W'(BYTES_PER_WORD - 1));
  assign o_word_valid = r_word_valid;
  assign o_word       = r_word;

  always_ff @(posedge clk) begin
    if (i_clear) begin
      r_lane       <= '0;
      r_shift      <= '0;
      r_word       <= '0;
      r_word_valid <= 1'b0;
    end else begin
      r_word_valid <= 1'b0;
      if (i_byte_en) begin
        r_lane <= r_lane + 1'b1;
        // The first three bytes collect in r_shift; the fourth completes the word.
        if (o_last_byte) begin
          r_word       <= {r_shift, i_byte};
          r_word_valid <= 1'b1;
        end else begin
          r_shift <= {r_shift[15:0], i_byte};
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a length-prefixed, XOR-checksummed byte stream into
// instruction-memory writes and holds the CPU in reset until the load is good.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int MAX_WORDS = 2 ** (ADDR_W - 2)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              error,
  output logic [2:0]        dbg_state
);

  localparam int LEN_W = 8 * LEN_BYTES;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_WORDS);

  state_e             r_state;
  state_e             w_next;
  logic [7:0]         r_len_hi;
  logic [7:0]         r_xor;
  logic [LEN_W-1:0]   r_words_left;
  logic [ADDR_W-3:0]  r_word_idx;

  logic               w_clear;
  logic               w_xfer;
  logic               w_data_en;
  logic [LEN_W-1:0]   w_len;
  logic               w_last_byte;
  logic               w_word_valid;
  logic [31:0]        w_word;

  // Handshake: a byte moves when byte_valid && byte_ready on a rising edge;
  // byte_ready depends only on state, and load_req/rst discard that cycle's byte.
  assign byte_ready = (r_state == ST_LEN_HI) || (r_state == ST_LEN_LO) ||
                      (r_state == ST_DATA)   || (r_state == ST_CSUM);
  assign w_clear    = rst || load_req;
  assign w_xfer     = byte_valid && byte_ready;
  assign w_data_en  = w_xfer && (r_state == ST_DATA) && !w_clear;
  assign w_len      = {r_len_hi, byte_data};

  imem_loader_byte_packer u_packer (
    .clk          (clk),
    .i_clear      (w_clear),
    .i_byte_en    (w_data_en),
    .i_byte       (byte_data),
    .o_last_byte  (w_last_byte),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  assign imem_we    = w_word_valid;
  assign imem_wdata = w_word;
  assign imem_waddr = {r_word_idx, 2'b00};
  assign cpu_rst    = (r_state != ST_DONE);
  assign done       = (r_state == ST_DONE);
  assign error      = (r_state == ST_ERROR);
  assign dbg_state  = r_state;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_LEN_HI: if (w_xfer) w_next = ST_LEN_LO;
      ST_LEN_LO: begin
        if (w_xfer) begin
          if (w_len > MAX_LEN)   w_next = ST_ERROR;
          else if (w_len == '0)  w_next = ST_CSUM;
          else                   w_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_xfer && w_last_byte && (r_words_left == LEN_W'(1))) w_next = ST_CSUM;
      end
      ST_CSUM: begin
        if (w_xfer) w_next = (byte_data == r_xor) ? ST_DONE : ST_ERROR;
      end
      default: w_next = r_state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_state      <= ST_LEN_HI;
      r_len_hi     <= '0;
      r_xor        <= '0;
      r_words_left <= '0;
      r_word_idx   <= '0;
    end else begin
      r_state <= w_next;
      if (w_xfer) begin
        case (r_state)
          ST_LEN_HI: begin
            r_len_hi <= byte_data;
            r_xor    <= csum_fold(r_xor, byte_data);
          end
          ST_LEN_LO: begin
            r_words_left <= w_len;
            r_xor        <= csum_fold(r_xor, byte_data);
          end
          ST_DATA: begin
            r_xor <= csum_fold(r_xor, byte_data);
            if (w_last_byte) r_words_left <= r_words_left - 1'b1;
          end
          default: ;
        endcase
      end
      // Index advances after the write pulse so imem_waddr covers the pulse cycle.
      if (w_word_valid) r_word_idx <= r_word_idx + 1'b1;
    end
  end

endmodule
